apb_master: RTL
===============

# apb_master

APB initiator that turns single-beat commands from an internal requester (CPU bridge or test sequencer) into APB transfers toward the UART register slave. It runs the SETUP/ACCESS phases, honours PREADY wait states, captures PRDATA/PSLVERR, and returns one response per command. An optional watchdog aborts transfers that stall.

## Interface
- ADDR_W, 32, PADDR and cmd_addr width
- DATA_W, 32, PWDATA/PRDATA and command/response data width
- TIMEOUT_CYCLES, 16, ACCESS cycles with PREADY=0 before abort; legal range 1..65535; used only when APB_MASTER_TIMEOUT_EN is defined
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborts
- rsp_err  out  1  PSLVERR at completion, or timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- PSEL  out  1  slave select
- PENABLE  out  1  access phase
- PWRITE  out  1  transfer direction
- PADDR  out  ADDR_W  address
- PWDATA  out  DATA_W  write data
- PRDATA  in  DATA_W  read data from slave
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On accept, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA; -> SETUP.
- SETUP: PSEL=1, PENABLE=0, cmd_ready=0; unconditionally -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1 at the edge: complete, -> IDLE. PREADY=0: stay.
- PWRITE/PADDR/PWDATA remain stable from SETUP through the final ACCESS cycle; they hold last value in IDLE (not cleared).
- Completion: rsp_valid=1 next cycle; rsp_err=PSLVERR; rsp_rdata=PRDATA for reads, 0 for writes; rsp_timeout=0. PSLVERR/PRDATA ignored in any cycle other than the completing one.
- Response data fields hold until the next rsp_valid; rsp_valid itself is exactly one cycle. No response backpressure.
- cmd_ready decoded from state register only; no combinational input-to-output path.

## Timing
- Reset (any state, including mid-ACCESS): next edge -> IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0; cmd_ready=1 after reset deasserts; no response for the aborted transfer; watchdog cleared.
- Accept at edge N: SETUP in cycle N..N+1, ACCESS from edge N+1. Zero wait states: completion at edge N+2, rsp_valid high cycle N+2..N+3, cmd_ready high same cycle.
- Each PREADY=0 ACCESS cycle adds one cycle latency.
- Back-to-back: a command held valid is accepted at the edge ending the rsp_valid cycle; minimum 3 cycles per transfer; PSEL drops for exactly one cycle between transfers.
- Command accepted in the same cycle rsp_valid is high is legal.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: 16-bit counter increments per ACCESS cycle with PREADY=0; reset on entering SETUP. When count reaches TIMEOUT_CYCLES while PREADY=0, next edge -> IDLE, PSEL/PENABLE=0, rsp_valid pulse with rsp_err=1, rsp_timeout=1, rsp_rdata=0. PREADY=1 on the reaching cycle wins: normal completion.
- Not defined: no counter, ACCESS waits indefinitely; rsp_timeout tied 0.

## Test plan
- Write addr 0x01 data 0x78, PREADY=1 always -> SETUP then ACCESS with PWRITE=1, PADDR=0x01, PWDATA=0x78; rsp_valid 2 edges after accept, rsp_err=0, rsp_rdata=0.
- Read addr 0x02, slave holds PREADY=0 two cycles then PRDATA=0x21, PREADY=1 -> ACCESS lasts 3 cycles, rsp_rdata=0x21, rsp_err=0.
- Read addr 0x10, slave returns PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_timeout=0; PSLVERR=1 during wait cycles alone never sets rsp_err.
- cmd_valid held high for writes 0x01/0x02/0x03 -> three transfers, one idle PSEL=0 cycle between each, 3 rsp_valid pulses 3 cycles apart.
- APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY stuck 0 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, PSEL=0; next command proceeds normally.
- Assert rst during 2nd ACCESS cycle of a stalled read -> next edge all outputs 0, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master.sv
// APB initiator: turns single-beat commands into APB SETUP/ACCESS transfers, one response each.
// Define APB_MASTER_TIMEOUT_EN to enable the stalled-ACCESS watchdog.
module apb_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              accept, complete, abort;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  assign accept   = (state_q == IDLE) && cmd_valid;
  assign complete = (state_q == ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_q;
  logic        rsp_timeout_q;

  // wd_cnt_q holds the number of stalled ACCESS cycles before the current one.
  assign abort = (state_q == ACCESS) && !PREADY && (wd_cnt_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      wd_cnt_q <= 16'd0;
    end else if ((state_q == ACCESS) && !PREADY) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_timeout_q <= 1'b0;
    end else if (complete) begin
      rsp_timeout_q <= 1'b0;
    end else if (abort) begin
      rsp_timeout_q <= 1'b1;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (complete || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transfer attributes hold their last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (accept) begin
      pwrite_q <= cmd_write;
      paddr_q  <= cmd_addr;
      pwdata_q <= cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= complete || abort;
      if (complete) begin
        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
        rsp_err_q   <= PSLVERR;
      end else if (abort) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
